// File: rtl/sha256_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sha256_mem_arbiter                                          |
// | Description : Round-robin arbiter sharing one word-wide memory port       |
// |               between NUM_CORES SHA-256 cores, with sticky all_done.      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module sha256_mem_arbiter #(
    parameter int NUM_CORES = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [NUM_CORES-1:0]        core_req_i,
    input  logic [NUM_CORES-1:0]        core_we_i,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr_i,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata_i,
    input  logic [NUM_CORES-1:0]        core_done_i,
    output logic [NUM_CORES-1:0]        core_gnt_o,
    output logic [NUM_CORES-1:0]        core_rvalid_o,
    output logic [DATA_W-1:0]           core_rdata_o,
    output logic                        mem_clk_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_write_data_o,
    input  logic [DATA_W-1:0]           mem_read_data_i,
    output logic                        all_done_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] gnt_q,     gnt_d;
    logic [NUM_CORES-1:0] rvalid_q,  rvalid_d;
    logic                 mem_we_q,  mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [IDX_W-1:0]     rr_ptr_q,  rr_ptr_d;
    logic                 all_done_q, all_done_d;

    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] elig_hi;
    logic [NUM_CORES-1:0] pick;
    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;

    // A core granted this cycle is still showing the consumed command.
    assign elig = core_req_i & ~gnt_q;

    // Cores at or above rr_ptr take precedence; otherwise wrap to the lowest.
    always_comb begin
        elig_hi = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            elig_hi[i] = elig[i] && (IDX_W'(i) >= rr_ptr_q);
        end
        pick    = (|elig_hi) ? elig_hi : elig;
        win_vld = |elig;
        win_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        gnt_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_vld && (win_idx == IDX_W'(i))) begin
                gnt_d[i]    = 1'b1;
                mem_we_d    = core_we_i[i];
                mem_addr_d  = core_addr_i[i*ADDR_W +: ADDR_W];
                mem_wdata_d = core_wdata_i[i*DATA_W +: DATA_W];
            end
        end
        if (win_vld) begin
            rr_ptr_d = (win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
        end
        if (start_i) begin
            rr_ptr_d = '0;
        end
    end

    // Read data arrives one cycle after the address, so rvalid trails a read grant.
    assign rvalid_d = gnt_q & {NUM_CORES{~mem_we_q}};

    always_comb begin
        all_done_d = all_done_q;
        if (start_i) begin
            all_done_d = 1'b0;
        end else if (&core_done_i) begin
            all_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rr_ptr_q    <= '0;
            all_done_q  <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            all_done_q  <= all_done_d;
        end
    end

    assign core_gnt_o       = gnt_q;
    assign core_rvalid_o    = rvalid_q;
    assign core_rdata_o     = mem_read_data_i;
    assign mem_clk_o        = clk_i;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_write_data_o = mem_wdata_q;
    assign all_done_o       = all_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sha256_mem_arbiter                                       |
// | Description : Directed self-checking bench for sha256_mem_arbiter.        |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_sha256_mem_arbiter;

    localparam int N  = 16;
    localparam int AW = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_we;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_done;
    logic [N-1:0]    core_gnt;
    logic [N-1:0]    core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            mem_clk;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data;
    logic            all_done;

    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [DW-1:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_addr[i*AW +: AW]  = addr_a[i];
            core_wdata[i*DW +: DW] = wdata_a[i];
        end
    end

    // Memory responder: data for the address on the bus appears the next cycle.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    sha256_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .core_req_i       (core_req),
        .core_we_i        (core_we),
        .core_addr_i      (core_addr),
        .core_wdata_i     (core_wdata),
        .core_done_i      (core_done),
        .core_gnt_o       (core_gnt),
        .core_rvalid_o    (core_rvalid),
        .core_rdata_o     (core_rdata),
        .mem_clk_o        (mem_clk),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mem_read_data),
        .all_done_o       (all_done)
    );

    typedef struct {
        logic         start;
        logic [N-1:0] req;
        logic [N-1:0] we;
        logic [N-1:0] done;
        logic [N-1:0] exp_gnt;
        logic         exp_we;
        logic [AW-1:0] exp_addr;
        logic         exp_all_done;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seen;

        tbl[0]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 16'h2000, 16'h0000, 16'h0000, 16'h2000, 1'b0, 16'h010D, 1'b0};
        tbl[2]  = '{1'b0, 16'h8004, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'h010F, 1'b0};
        tbl[3]  = '{1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h0004, 1'b0, 16'h0102, 1'b0};
        tbl[4]  = '{1'b0, 16'h0009, 16'h0008, 16'h0000, 16'h0008, 1'b1, 16'h0103, 1'b0};
        tbl[5]  = '{1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[12] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        for (int i = 0; i < N; i++) begin
            addr_a[i]  = AW'(16'h0100 + i);
            wdata_a[i] = 32'hA000_0000 + i;
        end
        mem[16'h0010] = 32'hDEAD_BEEF;

        // Reset held with every core requesting
        reset = 1'b1; start = 1'b0; core_req = '1; core_we = '0; core_done = '0;
        step();
        step();
        chk("rst_gnt",      core_gnt,       0);
        chk("rst_rvalid",   core_rvalid,    0);
        chk("rst_mem_we",   mem_we,         0);
        chk("rst_mem_addr", mem_addr,       0);
        chk("rst_mem_wd",   mem_write_data, 0);
        chk("rst_all_done", all_done,       0);
        reset = 1'b0;
        step();
        chk("post_rst_gnt", core_gnt, 16'h0001);
        core_req = '0;
        step();
        chk("post_rst_idle",   core_gnt,    0);
        chk("post_rst_rvalid", core_rvalid, 16'h0001);

        // Single read by core 3
        addr_a[3] = 16'h0010;
        core_req  = 16'h0008;
        step();
        chk("rd_gnt",    core_gnt, 16'h0008);
        chk("rd_addr",   mem_addr, 16'h0010);
        chk("rd_we",     mem_we,   0);
        core_req = '0;
        step();
        chk("rd_rvalid", core_rvalid, 16'h0008);
        chk("rd_rdata",  core_rdata,  32'hDEAD_BEEF);
        chk("rd_gnt_off", core_gnt,   0);
        addr_a[3] = 16'h0103;

        // Fairness with every core requesting from rr_ptr = 0
        start = 1'b1;
        step();
        start = 1'b0;
        core_req = '1;
        seen = '0;
        for (int k = 0; k < 17; k++) begin
            step();
            chk($sformatf("fair_gnt%0d", k),  core_gnt, 64'(1) << (k % 16));
            chk($sformatf("fair_addr%0d", k), mem_addr, 16'h0100 + (k % 16));
            if (k < 16) seen = seen | core_gnt;
        end
        chk("fair_all_seen", seen, 16'hFFFF);
        core_req = '0;
        step();
        chk("fair_idle", core_gnt, 0);

        // Table: wrap/skip arbitration and all_done behaviour
        for (int r = 0; r < 13; r++) begin
            start     = tbl[r].start;
            core_req  = tbl[r].req;
            core_we   = tbl[r].we;
            core_done = tbl[r].done;
            step();
            chk($sformatf("tbl%0d_gnt", r),      core_gnt, tbl[r].exp_gnt);
            chk($sformatf("tbl%0d_all_done", r), all_done, tbl[r].exp_all_done);
            if (tbl[r].exp_gnt != 0) begin
                chk($sformatf("tbl%0d_we", r),   mem_we,   tbl[r].exp_we);
                chk($sformatf("tbl%0d_addr", r), mem_addr, tbl[r].exp_addr);
            end
        end
        start = 1'b0; core_req = '0; core_we = '0; core_done = '0;

        // Write then read-back of the same address
        addr_a[0] = 16'h0020; wdata_a[0] = 32'h0000_1234;
        core_we = 16'h0001; core_req = 16'h0001;
        step();
        chk("mix_w_gnt",   core_gnt,       16'h0001);
        chk("mix_w_we",    mem_we,         1);
        chk("mix_w_addr",  mem_addr,       16'h0020);
        chk("mix_w_data",  mem_write_data, 32'h0000_1234);
        addr_a[1] = 16'h0020;
        core_we = '0; core_req = 16'h0002;
        step();
        chk("mix_r_gnt",    core_gnt,    16'h0002);
        chk("mix_r_we",     mem_we,      0);
        chk("mix_r_addr",   mem_addr,    16'h0020);
        chk("mix_no_wrval", core_rvalid, 0);
        core_req = '0;
        step();
        chk("mix_rvalid", core_rvalid, 16'h0002);
        chk("mix_rdata",  core_rdata,  32'h0000_1234);

        // Reset while a read is outstanding
        addr_a[5] = 16'h0010;
        core_req = 16'h0020;
        step();
        chk("rstrd_gnt", core_gnt, 16'h0020);
        core_req = '0;
        reset = 1'b1;
        step();
        chk("rstrd_rvalid0", core_rvalid, 0);
        chk("rstrd_gnt0",    core_gnt,    0);
        chk("rstrd_addr0",   mem_addr,    0);
        reset = 1'b0;
        step();
        chk("rstrd_rvalid1", core_rvalid, 0);
        step();
        chk("rstrd_rvalid2", core_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
